// File: rtl/hdmi_pkg.sv
// Shared types and constants for the HDMI period scheduler and its TMDS consumers.
package hdmi_pkg;

  // Mode encoding shared with the tmds_channel instances.
  typedef enum logic [2:0] {
    MODE_CTRL      = 3'd0,
    MODE_VIDEO     = 3'd1,
    MODE_VID_GUARD = 3'd2,
    MODE_ISL_DATA  = 3'd3,
    MODE_ISL_GUARD = 3'd4
  } tmds_mode_t;

  // Period sequencer states.
  typedef enum logic [2:0] {
    ST_CTRL,
    ST_VID_PRE,
    ST_VID_GUARD,
    ST_VIDEO,
    ST_ISL_PRE,
    ST_ISL_GUARD_L,
    ST_ISL_DATA,
    ST_ISL_GUARD_T
  } sched_state_t;

  // Preamble CTL pairs for channels 1 and 2.
  localparam logic [1:0] CTL_VID_PRE1 = 2'b01;
  localparam logic [1:0] CTL_VID_PRE2 = 2'b00;
  localparam logic [1:0] CTL_ISL_PRE  = 2'b01;
  localparam logic [1:0] CTL_IDLE     = 2'b00;

  // Period lengths in pixel clocks.
  localparam int PREAMBLE_LEN = 8;
  localparam int GUARD_LEN    = 2;
  localparam int PACKET_LEN   = 32;

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/hdmi_timing_counter.sv
// Raster position counters and sync generation. Also exposes the position of
// the next pixel so the scheduler can register outputs aligned with cx/cy.
module hdmi_timing_counter
  import hdmi_pkg::*;
#(
  parameter int H_ACTIVE     = 640,
  parameter int H_TOTAL      = 800,
  parameter int H_SYNC_START = 656,
  parameter int H_SYNC_END   = 752,
  parameter int V_ACTIVE     = 480,
  parameter int V_TOTAL      = 525,
  parameter int V_SYNC_START = 490,
  parameter int V_SYNC_END   = 492
) (
  input  logic        clk_pixel,
  input  logic        reset_n,
  output logic [11:0] cx,
  output logic [10:0] cy,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] cx_next,
  output logic [10:0] cy_next,
  output logic        active_next
);

  localparam logic [11:0] CX_LAST   = 12'(H_TOTAL - 1);
  localparam logic [10:0] CY_LAST   = 11'(V_TOTAL - 1);
  localparam logic [11:0] CX_ACTIVE = 12'(H_ACTIVE);
  localparam logic [10:0] CY_ACTIVE = 11'(V_ACTIVE);
  localparam logic [11:0] HS_START  = 12'(H_SYNC_START);
  localparam logic [11:0] HS_END    = 12'(H_SYNC_END);
  localparam logic [10:0] VS_START  = 11'(V_SYNC_START);
  localparam logic [10:0] VS_END    = 11'(V_SYNC_END);

  logic [11:0] cx_q, cx_d;
  logic [10:0] cy_q, cy_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;

  // Next raster position and the syncs/active flag that belong to it.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cx_d = cx_q + 12'd1;
    cy_d = cy_q;
    if (cx_q == CX_LAST) begin
      cx_d = '0;
      cy_d = (cy_q == CY_LAST) ? '0 : cy_q + 11'd1;
    end
    hsync_d     = (cx_d >= HS_START) && (cx_d < HS_END);
    vsync_d     = (cy_d >= VS_START) && (cy_d < VS_END);
    active_next = (cx_d < CX_ACTIVE) && (cy_d < CY_ACTIVE);
  end

  // Raster registers; reset parks on the first blanking line.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!reset_n) begin
      cx_q    <= '0;
      cy_q    <= CY_ACTIVE;
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
    end else begin
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign cx      = cx_q;
  assign cy      = cy_q;
  assign hsync   = hsync_q;
  assign vsync   = vsync_q;
  assign cx_next = cx_d;
  assign cy_next = cy_d;

endmodule

// File: rtl/hdmi_period_scheduler.sv
// HDMI 1.4a period sequencer: control, video preamble/guard/data and data
// islands with a per-packet accept handshake. All outputs are registered from
// the next raster position so they line up with cx/cy.
module hdmi_period_scheduler
  import hdmi_pkg::*;
#(
  parameter int H_ACTIVE     = 640,
  parameter int H_TOTAL      = 800,
  parameter int H_SYNC_START = 656,
  parameter int H_SYNC_END   = 752,
  parameter int V_ACTIVE     = 480,
  parameter int V_TOTAL      = 525,
  parameter int V_SYNC_START = 490,
  parameter int V_SYNC_END   = 492,
  parameter int ISLAND_START = 642,
  parameter int MAX_PACKETS  = 18
) (
  input  logic        clk_pixel,
  input  logic        reset_n,
  input  logic        dvi_mode,
  input  logic        packet_pending,
  output logic [11:0] cx,
  output logic [10:0] cy,
  output logic        hsync,
  output logic        vsync,
  output logic [2:0]  mode,
  output logic [1:0]  ch0_ctl,
  output logic [1:0]  ch1_ctl,
  output logic [1:0]  ch2_ctl,
  output logic        packet_start,
  output logic [4:0]  packet_cycle,
  output logic        island_first
);

  // Packets that fit between the island start and the video preamble with margin.
  localparam int BUDGET =
    min_int(MAX_PACKETS, (H_TOTAL - 14 - ISLAND_START - 12) / PACKET_LEN);

  localparam logic [11:0] CX_ISLAND      = 12'(ISLAND_START);
  localparam logic [11:0] CX_VID_PRE     = 12'(H_TOTAL - PREAMBLE_LEN - GUARD_LEN);
  localparam logic [11:0] CX_VID_GUARD   = 12'(H_TOTAL - GUARD_LEN);
  localparam logic [10:0] CY_LAST_ACTIVE = 11'(V_ACTIVE - 1);
  localparam logic [10:0] CY_LAST        = 11'(V_TOTAL - 1);
  localparam logic [2:0]  PRE_LAST       = 3'(PREAMBLE_LEN - 1);
  localparam logic [2:0]  GUARD_LAST     = 3'(GUARD_LEN - 1);
  localparam logic [4:0]  SLOT_LAST      = 5'(PACKET_LEN - 1);
  localparam logic [7:0]  BUDGET_C       = 8'(BUDGET);

  logic [11:0] cx_next;
  logic [10:0] cy_next;
  logic        active_next;
  logic        vid_pre_line;

  sched_state_t state_q, state_d, idle_state;
  tmds_mode_t   mode_q, mode_d;
  logic [2:0]   phase_q, phase_d;
  logic [4:0]   packet_cycle_q, packet_cycle_d;
  logic [7:0]   sent_q, sent_d;
  logic         dvi_q, dvi_d;
  logic [1:0]   ch1_q, ch1_d;
  logic [1:0]   ch2_q, ch2_d;
  logic         packet_start_q, packet_start_d;
  logic         island_first_q, island_first_d;

  hdmi_timing_counter #(
    .H_ACTIVE    (H_ACTIVE),
    .H_TOTAL     (H_TOTAL),
    .H_SYNC_START(H_SYNC_START),
    .H_SYNC_END  (H_SYNC_END),
    .V_ACTIVE    (V_ACTIVE),
    .V_TOTAL     (V_TOTAL),
    .V_SYNC_START(V_SYNC_START),
    .V_SYNC_END  (V_SYNC_END)
  ) u_timing (
    .clk_pixel  (clk_pixel),
    .reset_n    (reset_n),
    .cx         (cx),
    .cy         (cy),
    .hsync      (hsync),
    .vsync      (vsync),
    .cx_next    (cx_next),
    .cy_next    (cy_next),
    .active_next(active_next)
  );

  // DVI selection is latched at the start of each line and held for the whole line.
  always_comb begin
    dvi_d = dvi_q;
    if (cx_next == '0) dvi_d = dvi_mode;
  end

  // Where an idle (control/video) period goes next: island, video preamble or video.
  always_comb begin
    vid_pre_line = (cy_next < CY_LAST_ACTIVE) || (cy_next == CY_LAST);
    idle_state   = ST_CTRL;
    if (!dvi_d && cx_next == CX_ISLAND && packet_pending) begin
      idle_state = ST_ISL_PRE;
    end else if (!dvi_d && cx_next == CX_VID_PRE && vid_pre_line) begin
      idle_state = ST_VID_PRE;
    end else if (active_next) begin
      idle_state = ST_VIDEO;
    end
  end

  // Period sequencing and the packet-slot handshake.
  always_comb begin
    state_d        = state_q;
    phase_d        = phase_q;
    sent_d         = sent_q;
    packet_cycle_d = '0;
    packet_start_d = 1'b0;
    case (state_q)
      ST_CTRL, ST_VIDEO: begin
        state_d = idle_state;
        phase_d = '0;
      end
      ST_VID_PRE: begin
        if (cx_next == CX_VID_GUARD) state_d = ST_VID_GUARD;
      end
      ST_VID_GUARD: begin
        if (cx_next == '0) state_d = idle_state;
      end
      ST_ISL_PRE: begin
        if (phase_q == PRE_LAST) begin
          state_d = ST_ISL_GUARD_L;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 3'd1;
        end
      end
      ST_ISL_GUARD_L: begin
        if (phase_q == GUARD_LAST) begin
          state_d        = ST_ISL_DATA;
          phase_d        = '0;
          packet_start_d = 1'b1;
          sent_d         = 8'd1;
        end else begin
          phase_d = phase_q + 3'd1;
        end
      end
      ST_ISL_DATA: begin
        if (packet_cycle_q == SLOT_LAST) begin
          if (packet_pending && sent_q < BUDGET_C) begin
            packet_start_d = 1'b1;
            sent_d         = sent_q + 8'd1;
          end else begin
            state_d = ST_ISL_GUARD_T;
            phase_d = '0;
          end
        end else begin
          packet_cycle_d = packet_cycle_q + 5'd1;
        end
      end
      ST_ISL_GUARD_T: begin
        if (phase_q == GUARD_LAST) begin
          state_d = idle_state;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 3'd1;
        end
      end
      default: begin
        state_d = ST_CTRL;
        phase_d = '0;
      end
    endcase
  end

  // Output decode from the next state so registered outputs align with cx/cy.
  always_comb begin
    mode_d         = MODE_CTRL;
    ch1_d          = CTL_IDLE;
    ch2_d          = CTL_IDLE;
    island_first_d = 1'b0;
    case (state_d)
      ST_VID_PRE: begin
        ch1_d = CTL_VID_PRE1;
        ch2_d = CTL_VID_PRE2;
      end
      ST_VID_GUARD: mode_d = MODE_VID_GUARD;
      ST_VIDEO:     mode_d = MODE_VIDEO;
      ST_ISL_PRE: begin
        ch1_d = CTL_ISL_PRE;
        ch2_d = CTL_ISL_PRE;
      end
      ST_ISL_GUARD_L, ST_ISL_GUARD_T: mode_d = MODE_ISL_GUARD;
      ST_ISL_DATA: begin
        mode_d         = MODE_ISL_DATA;
        island_first_d = (packet_cycle_d == '0);
      end
      default: mode_d = MODE_CTRL;
    endcase
  end

  // Scheduler state and output registers; reset abandons any island immediately.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_CTRL;
      mode_q         <= MODE_CTRL;
      phase_q        <= '0;
      packet_cycle_q <= '0;
      sent_q         <= '0;
      dvi_q          <= 1'b0;
      ch1_q          <= CTL_IDLE;
      ch2_q          <= CTL_IDLE;
      packet_start_q <= 1'b0;
      island_first_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      mode_q         <= mode_d;
      phase_q        <= phase_d;
      packet_cycle_q <= packet_cycle_d;
      sent_q         <= sent_d;
      dvi_q          <= dvi_d;
      ch1_q          <= ch1_d;
      ch2_q          <= ch2_d;
      packet_start_q <= packet_start_d;
      island_first_q <= island_first_d;
    end
  end

  assign mode         = mode_q;
  assign ch0_ctl      = {vsync, hsync};
  assign ch1_ctl      = ch1_q;
  assign ch2_ctl      = ch2_q;
  assign packet_start = packet_start_q;
  assign packet_cycle = packet_cycle_q;
  assign island_first = island_first_q;

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Self-checking bench for hdmi_period_scheduler: a raster/island layout model
// predicts every output on every cycle under random packet/dvi stimulus.
module tb_hdmi_period_scheduler;

  localparam int H_ACTIVE     = 640;
  localparam int H_TOTAL      = 800;
  localparam int V_ACTIVE     = 480;
  localparam int V_TOTAL      = 525;
  localparam int ISLAND_START = 642;
  localparam int MAX_PACKETS  = 18;
  localparam int FIT          = (H_TOTAL - 14 - ISLAND_START - 12) / 32;
  localparam int BUDGET       = (FIT < MAX_PACKETS) ? FIT : MAX_PACKETS;

  logic        clk_pixel;
  logic        reset_n;
  logic        dvi_mode;
  logic        packet_pending;
  logic [11:0] cx;
  logic [10:0] cy;
  logic        hsync, vsync;
  logic [2:0]  mode;
  logic [1:0]  ch0_ctl, ch1_ctl, ch2_ctl;
  logic        packet_start;
  logic [4:0]  packet_cycle;
  logic        island_first;

  hdmi_period_scheduler dut (
    .clk_pixel     (clk_pixel),
    .reset_n       (reset_n),
    .dvi_mode      (dvi_mode),
    .packet_pending(packet_pending),
    .cx            (cx),
    .cy            (cy),
    .hsync         (hsync),
    .vsync         (vsync),
    .mode          (mode),
    .ch0_ctl       (ch0_ctl),
    .ch1_ctl       (ch1_ctl),
    .ch2_ctl       (ch2_ctl),
    .packet_start  (packet_start),
    .packet_cycle  (packet_cycle),
    .island_first  (island_first)
  );

  initial begin
    clk_pixel = 1'b0;
    forever #5 clk_pixel = ~clk_pixel;
  end

  int total = 0;
  int bad   = 0;

  // Reference model: raster position, the line's dvi selection, and the island
  // layout expressed as a packet count n (pre 8, guard 2, 32*n data, guard 2).
  int m_cx, m_cy, m_n;
  bit m_isl, m_dvi;
  logic [38:0] exp_vec, act_vec;

  task automatic model_reset();
    m_cx = 0; m_cy = V_ACTIVE; m_n = 0; m_isl = 0; m_dvi = 0;
  endtask

  task automatic model_expect();
    logic [2:0] md; logic [1:0] c1, c2; logic ps, fi, hs, vs; logic [4:0] pc;
    int off;
    md = 3'd0; c1 = 2'b00; c2 = 2'b00; ps = 0; fi = 0; pc = 5'd0;
    if (m_cx < H_ACTIVE && m_cy < V_ACTIVE) md = 3'd1;
    if (!m_dvi && (m_cy < V_ACTIVE - 1 || m_cy == V_TOTAL - 1)) begin
      if (m_cx >= H_TOTAL - 10 && m_cx <= H_TOTAL - 3) c1 = 2'b01;
      else if (m_cx >= H_TOTAL - 2) md = 3'd2;
    end
    if (m_isl && m_cx >= ISLAND_START) begin
      off = m_cx - ISLAND_START;
      if (off < 8) begin
        c1 = 2'b01; c2 = 2'b01;
      end else if (off < 10) begin
        md = 3'd4;
      end else if (off < 10 + 32 * m_n) begin
        md = 3'd3; pc = 5'((off - 10) % 32); ps = (pc == 5'd0); fi = ps;
      end else if (off < 12 + 32 * m_n) begin
        md = 3'd4;
      end
    end
    hs = (m_cx >= 656 && m_cx < 752);
    vs = (m_cy >= 490 && m_cy < 492);
    exp_vec = {12'(m_cx), 11'(m_cy), md, vs, hs, c1, c2, ps, pc, fi};
  endtask

  task automatic sample_dut();
    act_vec = {cx, cy, mode, ch0_ctl, ch1_ctl, ch2_ctl, packet_start, packet_cycle, island_first};
  endtask

  // One pixel clock: inputs seen at the edge feed the model, outputs sampled 1ns later.
  task automatic step();
    bit pend, dvi;
    pend = packet_pending;
    dvi  = dvi_mode;
    @(posedge clk_pixel);
    m_cx++;
    if (m_cx == H_TOTAL) begin
      m_cx = 0;
      m_cy = (m_cy == V_TOTAL - 1) ? 0 : m_cy + 1;
    end
    if (m_cx == 0) m_dvi = dvi;
    if (m_cx == ISLAND_START) begin
      m_isl = pend && !m_dvi;
      m_n   = 1;
    end else if (m_isl && m_cx == ISLAND_START + 10 + 32 * m_n && pend && m_n < BUDGET) begin
      m_n++;
    end
    #1;
    model_expect();
    sample_dut();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; dvi_mode = 1'b0; packet_pending = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_pixel);
    #1;
    model_expect(); sample_dut();
    total++;
    if (act_vec !== exp_vec) begin
      bad++; $display("FAIL reset_values got=%h want=%h", act_vec, exp_vec);
    end
    @(negedge clk_pixel);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      total++;
      if (act_vec !== exp_vec) begin
        bad++; $display("FAIL reset_count cx=%0d got=%h want=%h", m_cx, act_vec, exp_vec);
      end
    end
  endtask

  // Random pending everywhere except the island sampling cycle: no island this line.
  task automatic test_no_island();
    int starts = 0;
    while (!(m_cy == V_ACTIVE && m_cx == H_TOTAL - 1)) begin
      packet_pending = (m_cx == ISLAND_START - 1) ? 1'b0 : 1'($urandom_range(0, 1));
      step();
      if (packet_start === 1'b1) starts++;
      total++;
      if (act_vec !== exp_vec) begin
        bad++; $display("FAIL no_island cx=%0d cy=%0d got=%h want=%h", m_cx, m_cy, act_vec, exp_vec);
      end
    end
    total++;
    if (starts !== 0) begin
      bad++; $display("FAIL no_island_starts got=%0d want=0", starts);
    end
  endtask

  // Pending high over the entry and first slot end only: exactly two packets.
  task automatic test_two_packets();
    int starts = 0;
    int line = m_cy + 1;
    while (!(m_cy == line && m_cx == H_TOTAL - 1)) begin
      packet_pending = (m_cx >= 600 && m_cx < 700);
      step();
      if (packet_start === 1'b1) starts++;
      total++;
      if (act_vec !== exp_vec) begin
        bad++; $display("FAIL two_packets cx=%0d cy=%0d got=%h want=%h", m_cx, m_cy, act_vec, exp_vec);
      end
    end
    total++;
    if (starts !== 2) begin
      bad++; $display("FAIL two_packets_starts got=%0d want=2", starts);
    end
  endtask

  task automatic test_full_budget();
    int starts = 0;
    int line = m_cy + 1;
    packet_pending = 1'b1;
    while (!(m_cy == line && m_cx == H_TOTAL - 1)) begin
      step();
      if (packet_start === 1'b1) starts++;
      total++;
      if (act_vec !== exp_vec) begin
        bad++; $display("FAIL full_budget cx=%0d cy=%0d got=%h want=%h", m_cx, m_cy, act_vec, exp_vec);
      end
    end
    total++;
    if (starts !== BUDGET) begin
      bad++; $display("FAIL full_budget_starts got=%0d want=%0d", starts, BUDGET);
    end
  endtask

  // Random pending and occasional dvi flips (including mid-line) across blanking.
  task automatic test_random();
    while (!(m_cy == V_TOTAL - 2 && m_cx == 700)) begin
      packet_pending = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 199) == 0) dvi_mode = ~dvi_mode;
      step();
      total++;
      if (act_vec !== exp_vec) begin
        bad++; $display("FAIL random cx=%0d cy=%0d got=%h want=%h", m_cx, m_cy, act_vec, exp_vec);
      end
    end
  endtask

  // Line 524 into line 0: video preamble, guard, then active video.
  task automatic test_line_wrap();
    dvi_mode = 1'b0;
    while (!(m_cy == 1 && m_cx == 0)) begin
      packet_pending = 1'($urandom_range(0, 1));
      step();
      total++;
      if (act_vec !== exp_vec) begin
        bad++; $display("FAIL line_wrap cx=%0d cy=%0d got=%h want=%h", m_cx, m_cy, act_vec, exp_vec);
      end
      if (m_cy == V_TOTAL - 1 && m_cx == 795) begin
        total++;
        if (ch1_ctl !== 2'b01 || mode !== 3'd0) begin
          bad++; $display("FAIL vid_preamble ch1=%b mode=%0d want ch1=01 mode=0", ch1_ctl, mode);
        end
      end
      if (m_cy == 0 && m_cx == 0) begin
        total++;
        if (mode !== 3'd1) begin
          bad++; $display("FAIL video_start mode=%0d want=1", mode);
        end
      end
    end
  endtask

  // Line 2 latched as DVI; dvi drops mid-line 2 but only takes effect on line 3.
  task automatic test_dvi();
    int starts = 0;
    int odd_modes = 0;
    packet_pending = 1'b1;
    while (!(m_cy == 3 && m_cx == 0)) begin
      dvi_mode = (m_cy == 1) || (m_cy == 2 && m_cx < 300);
      step();
      if (m_cy == 2 && packet_start === 1'b1) starts++;
      if (m_cy == 2 && mode > 3'd1) odd_modes++;
      total++;
      if (act_vec !== exp_vec) begin
        bad++; $display("FAIL dvi cx=%0d cy=%0d got=%h want=%h", m_cx, m_cy, act_vec, exp_vec);
      end
    end
    total++;
    if (starts !== 0 || odd_modes !== 0) begin
      bad++; $display("FAIL dvi_suppress starts=%0d odd_modes=%0d want 0 and 0", starts, odd_modes);
    end
  endtask

  // Asynchronous reset while a packet is in flight, then normal restart.
  task automatic test_reset_mid_island();
    dvi_mode = 1'b0;
    packet_pending = 1'b1;
    while (!(m_cy == 3 && m_cx == 660)) begin
      step();
      total++;
      if (act_vec !== exp_vec) begin
        bad++; $display("FAIL pre_reset cx=%0d cy=%0d got=%h want=%h", m_cx, m_cy, act_vec, exp_vec);
      end
    end
    total++;
    if (mode !== 3'd3) begin
      bad++; $display("FAIL in_island mode=%0d want=3", mode);
    end
    #2;
    reset_n = 1'b0;
    #1;
    model_reset(); model_expect(); sample_dut();
    total++;
    if (act_vec !== exp_vec) begin
      bad++; $display("FAIL async_reset got=%h want=%h", act_vec, exp_vec);
    end
    repeat (2) @(negedge clk_pixel);
    packet_pending = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      total++;
      if (act_vec !== exp_vec) begin
        bad++; $display("FAIL post_reset cx=%0d got=%h want=%h", m_cx, act_vec, exp_vec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_no_island();
    test_two_packets();
    test_full_budget();
    test_random();
    test_line_wrap();
    test_dvi();
    test_reset_mid_island();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hdmi_period_scheduler.md
# hdmi_period_scheduler

Sequences the HDMI 1.4a period structure (control, video preamble/guard/data, data-island preamble/guard/packets) for one pixel clock domain. Owns the raster counters, drives the shared `mode` and per-channel CTL inputs of the three `tmds_channel` instances, and grants data-island packet slots to an upstream packet source through a per-packet handshake.

## Interface

Parameters:
- `H_ACTIVE` 640: active pixels per line.
- `H_TOTAL` 800: pixels per line.
- `H_SYNC_START` 656, `H_SYNC_END` 752: hsync high for `H_SYNC_START <= cx < H_SYNC_END`.
- `V_ACTIVE` 480, `V_TOTAL` 525: lines.
- `V_SYNC_START` 490, `V_SYNC_END` 492: vsync high for lines in `[V_SYNC_START, V_SYNC_END)`.
- `ISLAND_START` 642: cx at which an island preamble may begin.
- `MAX_PACKETS` 18: upper bound on packets per island.

Ports:
- `clk_pixel` in 1: pixel clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `dvi_mode` in 1: 1 = no preambles, guards or islands; only modes 0/1.
- `packet_pending` in 1: source has a complete packet ready.
- `cx` out 12: current pixel column.
- `cy` out 11: current line.
- `hsync`, `vsync` out 1: positive-polarity syncs.
- `mode` out 3: 0 control, 1 video, 2 video guard, 3 island data, 4 island guard.
- `ch0_ctl` out 2: {vsync, hsync}.
- `ch1_ctl`, `ch2_ctl` out 2: preamble CTL pairs.
- `packet_start` out 1: one-cycle pulse, first cycle of a packet slot (the handshake accept).
- `packet_cycle` out 5: 0..31 within the current packet; 0 outside islands.
- `island_first` out 1: high when `packet_cycle == 0` in mode 3 (drives ch0 TERC4 bit 3 low).

## Operation

- FSM states: CTRL, VID_PRE(8), VID_GUARD(2), VIDEO, ISL_PRE(8), ISL_GUARD_L(2), ISL_DATA(32·n), ISL_GUARD_T(2). The counts in parentheses are the cycles spent in each state.
- Raster: cx wraps at `H_TOTAL-1` to 0 and increments cy. cy wraps at `V_TOTAL-1` to 0.
- VIDEO: cx < H_ACTIVE and cy < V_ACTIVE. mode=1, ch1/ch2_ctl=00.
- Video preamble: only on lines whose next line is active (cy < V_ACTIVE-1, or cy == V_TOTAL-1). It occupies cx ∈ [H_TOTAL-10, H_TOTAL-3] with mode=0, ch1_ctl=01, ch2_ctl=00. VID_GUARD follows at cx ∈ [H_TOTAL-2, H_TOTAL-1] with mode=2.
- Island budget: localparam `BUDGET = min(MAX_PACKETS, (H_TOTAL-14-ISLAND_START-12)/32)`, which is 4 with the defaults.
- Island entry: at cx == ISLAND_START (any line) with `packet_pending`=1 and dvi_mode=0, enter ISL_PRE. ISL_PRE has mode=0, ch1_ctl=01, ch2_ctl=01. If `packet_pending`=0 at that cycle, there is no island on this line.
- Island guards (ISL_GUARD_L and ISL_GUARD_T): mode=4.
- Packet handshake: on each ISL_DATA slot start, `packet_start`=1 and the source treats this as having consumed one packet.
  - At `packet_cycle == 31`, continue to a new slot iff `packet_pending`=1 and packets_sent < BUDGET.
  - Otherwise go to ISL_GUARD_T, then CTRL.
- Outside VIDEO and the preambles, ch1_ctl and ch2_ctl are 00.
- dvi_mode=1: VID_PRE, VID_GUARD and all island states are suppressed, so mode is 1 in the active area and 0 elsewhere. dvi_mode is sampled at cx == 0 of each line. Changing it mid-line has no effect until the next line.

## Timing

- All outputs are registered and updated on the same edge as cx/cy, so every output is aligned with the cx/cy it corresponds to. `tmds_channel` adds one further cycle downstream.
- `packet_pending` is sampled only at cx == ISLAND_START and at `packet_cycle == 31`.
- Reset values: cx=0, cy=V_ACTIVE, state CTRL, mode=0, all ctl=00, hsync=vsync=0, packet_start=0, packet_cycle=0, island_first=0.
- Reset asserted mid-island: immediate return to reset values, with no trailing guard. The source must treat reset as a drop of the in-flight packet.
- With defaults, the worst-case island ends at cx=642+8+2+128+2-1=781, which is ≤ 786 (≥4 control cycles before the video preamble).

## Structure

- `hdmi_pkg`:
  - `tmds_mode_t` enum, with values 0..4 matching `tmds_channel` mode encoding.
  - Preamble CTL constants: `CTL_VID_PRE1=2'b01`, `CTL_VID_PRE2=2'b00`, `CTL_ISL_PRE=2'b01`.
  - Guard/preamble length constants (8, 2).
- Sub-module `hdmi_timing_counter`: owns cx/cy, hsync/vsync and the active flag. It takes the same raster parameters and `reset_n`. The FSM stays in `hdmi_period_scheduler`.

## Test plan

- Reset: hold reset_n low for 3 cycles, then release → all outputs at reset values; cy=480, cx counts 0,1,2…
- Line 524 → 0: mode=0 with ch1_ctl=01, ch2_ctl=00 for cx 790..797; mode=2 for cx 798..799; mode=1 at cy=0, cx=0..639; mode=0 at cx=640.
- Island with `packet_pending` high for exactly 2 packets:
  - ISL_PRE at cx 642..649, mode=4 at 650..651.
  - packet_start at cx 652 and 684; island_first high on those cycles.
  - mode=4 at 716..717, mode=0 at 718.
- `packet_pending` permanently high: exactly 4 packet_start pulses per line; mode=4 at cx 780..781.
- `packet_pending`=0 at cx 642: mode stays 0 through blanking; ch1_ctl/ch2_ctl=00 until cx 790.
- dvi_mode=1 with `packet_pending`=1: mode ∈ {0,1} only, no packet_start pulses. Reset_n pulled low at cx 660 in ISL_DATA: outputs return to reset values asynchronously.
